// File: rtl/gain_amp_pkg.sv
// ---------------------------------------------------------------------------
// gain_amp_pkg
// Shared constants and helpers for the multi-channel gain amplifier.
//   DATA_W_DEF / GAIN_W_DEF / GAIN_FRAC_DEF : default datapath geometry
//   GAIN_UNITY                              : gain code for x1.0
//   sat_max / sat_min                       : signed rails for a given width
// No ports (package).
// ---------------------------------------------------------------------------
package gain_amp_pkg;

    localparam int DATA_W_DEF    = 14;
    localparam int GAIN_W_DEF    = 8;
    localparam int GAIN_FRAC_DEF = 4;
    localparam int GAIN_UNITY    = 1 << GAIN_FRAC_DEF;

    // Largest value a two's-complement number of width w can hold.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Most negative value a two's-complement number of width w can hold.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/gain_amp_lane.sv
// ---------------------------------------------------------------------------
// gain_amp_lane
// One channel of the scaler: stage 1 multiplies the signed sample by the
// unsigned gain, stage 2 shifts out the gain fraction and clamps to the
// sample rails.
// Optional build macro: MULTI_CH_GAIN_AMP_ROUND_EN (round half up before the
// shift instead of plain floor).
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en1_i        : load stage 1 (input sample valid)
//   en2_i        : load stage 2 (stage 1 holds a valid product)
//   data_i       : signed input sample
//   gain_i       : unsigned fixed-point gain for this sample
//   data_o       : scaled, saturated sample (holds between valids)
//   clip_o       : stage 2 result is being clamped (qualify with en2_i)
// ---------------------------------------------------------------------------
module gain_amp_lane
    import gain_amp_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int GAIN_W    = GAIN_W_DEF,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en1_i,
    input  logic              en2_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [GAIN_W-1:0] gain_i,
    output logic [DATA_W-1:0] data_o,
    output logic              clip_o
);

    localparam int PW = DATA_W + GAIN_W + 1;
    localparam int SW = PW + 1;

    localparam logic signed [SW-1:0] MAXV = SW'(sat_max(DATA_W));
    localparam logic signed [SW-1:0] MINV = SW'(sat_min(DATA_W));
`ifdef MULTI_CH_GAIN_AMP_ROUND_EN
    localparam logic signed [SW-1:0] BIAS = SW'(1 << (GAIN_FRAC - 1));
`else
    localparam logic signed [SW-1:0] BIAS = '0;
`endif

    logic        [PW-1:0] dataExt;
    logic        [PW-1:0] gainExt;
    logic        [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q;
    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] scaled;
    logic        [DATA_W-1:0] data_d;
    logic        [DATA_W-1:0] data_q;

    // The sample is sign-extended and the gain zero-extended to the full
    // product width, so the low PW bits of the unsigned product are the
    // exact signed product; PW bits can never overflow.
    always_comb begin
        dataExt = {{(PW - DATA_W){data_i[DATA_W-1]}}, data_i};
        gainExt = {{(PW - GAIN_W){1'b0}}, gain_i};
        prod_d  = dataExt * gainExt;
    end

    // Stage 1 register: only a valid input sample replaces the product.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q <= '0;
        end else if (en1_i) begin
            prod_q <= prod_d;
        end
    end

    // One extra guard bit absorbs the rounding bias; the arithmetic shift
    // floors toward minus infinity, then the result is clamped to the rails.
    always_comb begin
        biased = {prod_q[PW-1], prod_q} + BIAS;
        scaled = biased >>> GAIN_FRAC;
        clip_o = 1'b0;
        data_d = scaled[DATA_W-1:0];
        if (scaled > MAXV) begin
            clip_o = 1'b1;
            data_d = MAXV[DATA_W-1:0];
        end else if (scaled < MINV) begin
            clip_o = 1'b1;
            data_d = MINV[DATA_W-1:0];
        end
    end

    // Stage 2 register: holds the last output while no valid flows through.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (en2_i) begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/multi_ch_gain_amp.sv
// ---------------------------------------------------------------------------
// multi_ch_gain_amp
// N-channel signed sample scaler with per-channel fixed-point gain, a
// glitch-free shadow/active gain scheme, a 2-cycle valid pipeline and
// sticky saturation monitoring.
// Optional build macro: MULTI_CH_GAIN_AMP_ROUND_EN (used by gain_amp_lane).
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   in_valid_i    : all channels of in_data_i are sampled this cycle
//   in_data_i     : packed signed samples, channel k at [k*DATA_W +: DATA_W]
//   gain_i        : packed new gains, same packing
//   gain_we_i     : capture gain_i into the shadow register
//   sat_clr_i     : clear sticky flags and the saturation counter
//   out_valid_o   : output strobe, 2 cycles after in_valid_i
//   out_data_o    : packed scaled, saturated samples
//   sat_o         : sticky per-channel clip flags
//   sat_cnt_o     : number of output samples with any clip (saturating)
// ---------------------------------------------------------------------------
module multi_ch_gain_amp
    import gain_amp_pkg::*;
#(
    parameter int                CH_N      = 2,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                GAIN_W    = GAIN_W_DEF,
    parameter int                GAIN_FRAC = GAIN_FRAC_DEF,
    parameter logic [GAIN_W-1:0] GAIN_RST  = 8'h20,
    parameter int                CNT_W     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    input  logic [CH_N*DATA_W-1:0]   in_data_i,
    input  logic [CH_N*GAIN_W-1:0]   gain_i,
    input  logic                     gain_we_i,
    input  logic                     sat_clr_i,
    output logic                     out_valid_o,
    output logic [CH_N*DATA_W-1:0]   out_data_o,
    output logic [CH_N-1:0]          sat_o,
    output logic [CNT_W-1:0]         sat_cnt_o
);

    logic [CH_N*GAIN_W-1:0] activeGain_q;
    logic [CH_N*GAIN_W-1:0] shadowGain_q;
    logic                   pending_q;
    logic [CH_N*GAIN_W-1:0] effGain;
    logic                   stage1Valid_q;
    logic                   outValid_q;
    logic [CH_N-1:0]        clipVec;
    logic                   anyClip;
    logic [CH_N-1:0]        satFlags_d;
    logic [CH_N-1:0]        satFlags_q;
    logic [CNT_W-1:0]       satCnt_d;
    logic [CNT_W-1:0]       satCnt_q;

    // A pending shadow gain takes effect on the very sample that commits it;
    // a write in the same cycle only lands in the shadow, so that sample
    // still sees the previously committed value.
    assign effGain = pending_q ? shadowGain_q : activeGain_q;

    // Shadow/active gain registers. A write keeps pending set even when a
    // valid sample commits the previous shadow in the same cycle, so the
    // newest write applies to the following valid sample.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            activeGain_q <= {CH_N{GAIN_RST}};
            shadowGain_q <= {CH_N{GAIN_RST}};
            pending_q    <= 1'b0;
        end else begin
            if (in_valid_i) begin
                activeGain_q <= effGain;
            end
            if (gain_we_i) begin
                shadowGain_q <= gain_i;
                pending_q    <= 1'b1;
            end else if (in_valid_i) begin
                pending_q    <= 1'b0;
            end
        end
    end

    // Valid pipeline mirrors the two datapath stages; reset flushes it so
    // in-flight samples never produce an output strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage1Valid_q <= 1'b0;
            outValid_q    <= 1'b0;
        end else begin
            stage1Valid_q <= in_valid_i;
            outValid_q    <= stage1Valid_q;
        end
    end

    // One datapath lane per channel, all sharing the valid pipeline.
    for (genvar k = 0; k < CH_N; k++) begin : gLane
        gain_amp_lane #(
            .DATA_W    (DATA_W),
            .GAIN_W    (GAIN_W),
            .GAIN_FRAC (GAIN_FRAC)
        ) uLane (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en1_i  (in_valid_i),
            .en2_i  (stage1Valid_q),
            .data_i (in_data_i[k*DATA_W +: DATA_W]),
            .gain_i (effGain[k*GAIN_W +: GAIN_W]),
            .data_o (out_data_o[k*DATA_W +: DATA_W]),
            .clip_o (clipVec[k])
        );
    end

    assign anyClip = stage1Valid_q & (|clipVec);

    // Saturation bookkeeping is updated in the same cycle the clipped sample
    // is registered into the output, so flags and counter change together
    // with out_valid_o. A clear that coincides with a new clip keeps the
    // new clip (flag set, counter restarts at 1); the counter never wraps.
    always_comb begin
        satFlags_d = satFlags_q;
        satCnt_d   = satCnt_q;
        if (sat_clr_i) begin
            satFlags_d = stage1Valid_q ? clipVec : '0;
            satCnt_d   = anyClip ? CNT_W'(1) : '0;
        end else if (stage1Valid_q) begin
            satFlags_d = satFlags_q | clipVec;
            if (anyClip && (satCnt_q != '1)) begin
                satCnt_d = satCnt_q + CNT_W'(1);
            end
        end
    end

    // Registered sticky flags and event counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            satFlags_q <= '0;
            satCnt_q   <= '0;
        end else begin
            satFlags_q <= satFlags_d;
            satCnt_q   <= satCnt_d;
        end
    end

    assign out_valid_o = outValid_q;
    assign sat_o       = satFlags_q;
    assign sat_cnt_o   = satCnt_q;

endmodule

// File: tb/tb_multi_ch_gain_amp.sv
// ---------------------------------------------------------------------------
// tb_multi_ch_gain_amp
// Self-checking bench: a behavioural gain/scale model pushes expected
// outputs into a scoreboard when samples are driven; a negedge monitor pops
// and compares them when out_valid_o is seen, including the exact latency.
// A second instance with a 3-bit counter exercises the non-wrapping counter.
// ---------------------------------------------------------------------------
module tb_multi_ch_gain_amp;

    localparam int CH_N   = 2;
    localparam int DATA_W = 14;
    localparam int GAIN_W = 8;

    typedef struct {
        logic signed [DATA_W-1:0] d0;
        logic signed [DATA_W-1:0] d1;
        int                       stamp;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   in_valid_i = 1'b0;
    logic [CH_N*DATA_W-1:0] in_data_i = '0;
    logic [CH_N*GAIN_W-1:0] gain_i = '0;
    logic                   gain_we_i = 1'b0;
    logic                   sat_clr_i = 1'b0;
    logic                   out_valid_o;
    logic [CH_N*DATA_W-1:0] out_data_o;
    logic [CH_N-1:0]        sat_o;
    logic [15:0]            sat_cnt_o;

    logic                   cValid = 1'b0;
    logic [CH_N*DATA_W-1:0] cData = '0;
    logic                   cOutValid;
    logic [CH_N*DATA_W-1:0] cOutData;
    logic [CH_N-1:0]        cSat;
    logic [2:0]             cSatCnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses = 0;
    exp_t sb[$];

    logic [CH_N*GAIN_W-1:0] mActive;
    logic [CH_N*GAIN_W-1:0] mShadow;
    bit                     mPending;

    multi_ch_gain_amp dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .gain_i      (gain_i),
        .gain_we_i   (gain_we_i),
        .sat_clr_i   (sat_clr_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .sat_o       (sat_o),
        .sat_cnt_o   (sat_cnt_o)
    );

    multi_ch_gain_amp #(.CNT_W(3)) dutCnt (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (cValid),
        .in_data_i   (cData),
        .gain_i      ('0),
        .gain_we_i   (1'b0),
        .sat_clr_i   (1'b0),
        .out_valid_o (cOutValid),
        .out_data_o  (cOutData),
        .sat_o       (cSat),
        .sat_cnt_o   (cSatCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference scaling: exact product, optional half-up bias, floor shift,
    // clamp to the 14-bit rails.
    function automatic logic signed [DATA_W-1:0] scale(input int x, input int g);
        longint p;
        p = longint'(x) * longint'(g);
`ifdef MULTI_CH_GAIN_AMP_ROUND_EN
        p = p + 8;
`endif
        p = p >>> 4;
        if (p > 8191) p = 8191;
        if (p < -8192) p = -8192;
        return DATA_W'(p);
    endfunction

    task automatic modelReset();
        mActive  = {2{8'h20}};
        mShadow  = {2{8'h20}};
        mPending = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of inputs at the negedge and record what the DUT
    // must produce two cycles later.
    task automatic drive(input bit v, input int a, input int b,
                         input bit we, input logic [15:0] g, input bit clr);
        logic [15:0] eff;
        exp_t        e;
        @(negedge clk);
        in_valid_i = v;
        in_data_i  = {14'(b), 14'(a)};
        gain_we_i  = we;
        gain_i     = g;
        sat_clr_i  = clr;
        eff = mPending ? mShadow : mActive;
        if (v) begin
            e.d0    = scale(a, int'(eff[7:0]));
            e.d1    = scale(b, int'(eff[15:8]));
            e.stamp = cyc;
            sb.push_back(e);
            mActive = eff;
        end
        if (we) begin
            mShadow  = g;
            mPending = 1'b1;
        end else if (v) begin
            mPending = 1'b0;
        end
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("[TB] FAIL %s drain: %0d outputs missing, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard monitor: every output strobe must match the oldest
    // expectation, at exactly two cycles after its input.
    always @(negedge clk) begin
        if (!rst_i && out_valid_o) begin
            pulses++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected out_valid at cycle %0d, data=%h", cyc, out_data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ($signed(out_data_o[13:0]) !== e.d0 || $signed(out_data_o[27:14]) !== e.d1
                    || cyc !== e.stamp + 2) begin
                    errors++;
                    $display("[TB] FAIL output: got ch0=%0d ch1=%0d at cycle %0d, required ch0=%0d ch1=%0d at cycle %0d",
                             $signed(out_data_o[13:0]), $signed(out_data_o[27:14]), cyc,
                             e.d0, e.d1, e.stamp + 2);
                end
            end
        end
    end

    task automatic test_reset();
        modelReset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== '0 || sat_o !== 2'b00 || sat_cnt_o !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset state: valid=%b data=%h sat=%b cnt=%h, required all zero",
                     out_valid_o, out_data_o, sat_o, sat_cnt_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        drive(1'b1, 1000, -1000, 1'b0, 16'h0, 1'b0);
        idle();
        drain("basic");
        checks++;
        if (sat_o !== 2'b00 || sat_cnt_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL basic sat: sat=%b cnt=%0d, required 00 / 0", sat_o, sat_cnt_o);
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 5000, -5000, 1'b0, 16'h0, 1'b0);
        idle();
        drain("sat rails");
        checks++;
        if (sat_o !== 2'b11 || sat_cnt_o !== 16'd1) begin
            errors++;
            $display("[TB] FAIL sat first clip: sat=%b cnt=%0d, required 11 / 1", sat_o, sat_cnt_o);
        end
        drive(1'b1, 10, 10, 1'b0, 16'h0, 1'b0);
        idle();
        drain("sat sticky");
        checks++;
        if (sat_o !== 2'b11 || sat_cnt_o !== 16'd1) begin
            errors++;
            $display("[TB] FAIL sat sticky: sat=%b cnt=%0d, required 11 / 1", sat_o, sat_cnt_o);
        end
    endtask

    task automatic test_gain_update();
        drive(1'b1, -3, -3, 1'b1, {2{8'h18}}, 1'b0);
        drive(1'b1, -3, -3, 1'b0, 16'h0, 1'b0);
        idle();
        drain("gain same-cycle");
        drive(1'b0, 0, 0, 1'b1, {2{8'h40}}, 1'b0);
        drive(1'b0, 0, 0, 1'b1, {8'h30, 8'h10}, 1'b0);
        drive(1'b1, 7, 7, 1'b0, 16'h0, 1'b0);
        idle();
        drain("gain last write");
        drive(1'b0, 0, 0, 1'b1, {8'h00, 8'hFF}, 1'b0);
        drive(1'b1, 1000, -1000, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, {8'hFF, 8'h00}, 1'b0);
        drive(1'b1, 1000, -1000, 1'b0, 16'h0, 1'b0);
        idle();
        drain("gain max/zero");
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 0, 0, 1'b1, {2{8'h20}}, 1'b0);
        drive(1'b1, 1, 1, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 2, 2, 1'b0, 16'h0, 1'b0);
        idle();
        drive(1'b1, 3, 3, 1'b0, 16'h0, 1'b0);
        idle();
        drain("back to back");
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ($signed(out_data_o[13:0]) !== 14'sd6 || $signed(out_data_o[27:14]) !== 14'sd6) begin
            errors++;
            $display("[TB] FAIL hold: data=%h while idle, required both channels 6", out_data_o);
        end
    endtask

    task automatic test_sat_clear();
        drive(1'b1, 8000, 10, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 16'h0, 1'b1);
        idle();
        drain("clear vs clip");
        checks++;
        if (sat_o !== 2'b01 || sat_cnt_o !== 16'd1) begin
            errors++;
            $display("[TB] FAIL clear vs clip: sat=%b cnt=%0d, required 01 / 1", sat_o, sat_cnt_o);
        end
        drive(1'b0, 0, 0, 1'b0, 16'h0, 1'b1);
        idle();
        #1;
        checks++;
        if (sat_o !== 2'b00 || sat_cnt_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL plain clear: sat=%b cnt=%0d, required 00 / 0", sat_o, sat_cnt_o);
        end
    endtask

    task automatic test_counter_sticky();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cValid = 1'b1;
            cData  = {14'sd8000, 14'sd8000};
        end
        @(negedge clk);
        cValid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (cSatCnt !== 3'd7 || cSat !== 2'b11) begin
            errors++;
            $display("[TB] FAIL counter sticky: cnt=%0d sat=%b, required 7 / 11", cSatCnt, cSat);
        end
    endtask

    task automatic test_reset_flush();
        drive(1'b0, 0, 0, 1'b1, {2{8'h30}}, 1'b0);
        drive(1'b1, 10, 10, 1'b0, 16'h0, 1'b0);
        idle();
        drain("flush pre");
        drive(1'b1, 100, 100, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        in_data_i  = {14'sd200, 14'sd200};
        in_valid_i = 1'b1;
        rst_i      = 1'b1;
        modelReset();
        pulses = 0;
        @(negedge clk);
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL flush: %0d out_valid pulses after reset, required 0", pulses);
        end
        checks++;
        if (sat_o !== 2'b00 || sat_cnt_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL flush sat: sat=%b cnt=%0d, required 00 / 0", sat_o, sat_cnt_o);
        end
        drive(1'b1, 100, -100, 1'b0, 16'h0, 1'b0);
        idle();
        drain("flush gain reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_gain_update();
        test_back_to_back();
        test_sat_clear();
        test_counter_sticky();
        test_reset_flush();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_ch_gain_amp.md
Name: multi_ch_gain_amp

Overview:
- Parametrised successor to the fixed x2 amplifier.
- N-channel signed sample scaler with a per-channel programmable fixed-point gain, applied to ADC/DAC data streams.
- 2-stage pipeline (multiply, then shift/saturate), valid-qualified.
- Gain updates are glitch-free on sample boundaries; per-channel sticky saturation flags plus a saturation event counter support monitoring.

Parameters:
- CH_N, 2: number of channels.
- DATA_W, 14: signed sample width per channel.
- GAIN_W, 8: unsigned gain width per channel.
- GAIN_FRAC, 4: fractional bits of gain (default format Q4.4).
- GAIN_RST, 8'h20: reset gain for all channels (2.0 in Q4.4).
- CNT_W, 16: saturation event counter width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  input sample strobe; all channels are sampled together.
- in_data_i  in  CH_N*DATA_W  signed samples; channel k occupies [k*DATA_W +: DATA_W].
- gain_i  in  CH_N*GAIN_W  new gains, same packing as in_data_i.
- gain_we_i  in  1  load gain_i into the shadow register.
- sat_clr_i  in  1  clear sticky flags and counter.
- out_valid_o  out  1  output sample strobe.
- out_data_o  out  CH_N*DATA_W  scaled, saturated samples.
- sat_o  out  CH_N  sticky per-channel saturation flag.
- sat_cnt_o  out  CNT_W  count of output samples in which any channel saturated.

Behaviour:
- Reset (async assert, sync release): out_valid_o=0, out_data_o=0, sat_o=0, sat_cnt_o=0, active and shadow gains=GAIN_RST, pending flag=0.
- Gain update:
  - gain_we_i=1 captures gain_i into the shadow register and sets pending.
  - Shadow is copied to active on the next cycle with in_valid_i=1, and pending clears.
  - That sample already uses the new gain.
  - gain_we_i and in_valid_i in the same cycle: that sample uses the OLD gain; the new gain applies from the next valid sample.
  - Repeated gain_we_i before a valid sample: last write wins.
- Stage 1 (on in_valid_i): prod_k = signed(in_k) * signed({1'b0,gain_k}). Width is DATA_W+GAIN_W+1; no overflow is possible at this width.
- Stage 2:
  - scaled_k = prod_k >>> GAIN_FRAC (arithmetic shift, floor toward -inf).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Latency: out_valid_o asserts exactly 2 cycles after in_valid_i; throughput is 1 sample/cycle.
- Valid bubbles propagate unchanged.
- out_data_o holds its last value while out_valid_o=0.
- Saturation:
  - Any clipped channel on a valid output sets sat_o[k].
  - sat_cnt_o increments by 1 per valid output with at least one clip.
  - sat_cnt_o sticks at all-ones and does not wrap.
- sat_clr_i clears sat_o and sat_cnt_o. If a new clip occurs in the same cycle, the set wins: the flag becomes 1 and the counter becomes 1.
- Gain 0 yields 0 output.
- Maximum gain 15.9375 must saturate correctly at both rails.
- rst_i mid-stream flushes the pipeline; no out_valid_o is produced for in-flight samples.

Optional Feature:
- Macro: MULTI_CH_GAIN_AMP_ROUND_EN.
- Defined: stage 2 adds 2^(GAIN_FRAC-1) to prod_k before the shift (round half up), then saturates as above.
- Undefined: truncation (floor) only.
- Latency is 2 cycles in both builds.

Decomposition:
- Shared package gain_amp_pkg: DATA_W/GAIN_W/GAIN_FRAC defaults, GAIN_UNITY constant (1<<GAIN_FRAC), and sat_max/sat_min helper functions.
- One sub-module: gain_amp_lane (a single channel's 2-stage multiply/shift/saturate datapath, with a clip output), instantiated CH_N times via generate.
- Gain shadow/pending logic, valid pipeline, and counter stay in the top module.

Test Plan:
- Reset gain 2.0, ch0=1000, ch1=-1000, one valid -> 2 cycles later out=2000/-2000, sat_o=00, sat_cnt_o=0.
- Gain 2.0, ch0=5000, ch1=-5000 -> out=8191/-8192, sat_o=11, sat_cnt_o=1. Next sample 10/10 -> sat_o stays 11, cnt stays 1.
- gain_we_i with 8'h18 (1.5) in the same cycle as valid sample -3 -> output -6 (old gain). Next sample -3 -> -5 (floor); with ROUND_EN -> -4.
- Back-to-back valids 1,2,3 with a one-cycle bubble after 2 -> outputs 2,4,_,6 with matching out_valid_o pattern and exact 2-cycle latency.
- sat_clr_i asserted in the same cycle as a clipping output -> sat_o bit=1, sat_cnt_o=1. Separately, counter preloaded to 16'hFFFE plus 3 clips -> 16'hFFFF.
- rst_i asserted for 1 cycle while two samples are in flight -> out_valid_o never pulses for them; gains return to 8'h20.
